tt_um_rps_challenger: RTL and testbench

TT_UM_RPS_CHALLENGER -- requirements
Module: tt_um_rps_challenger

---
 rtl/rps_pkg.sv | 35 +++
 rtl/rps_lfsr.sv | 25 ++
 rtl/tt_um_rps_challenger.sv | 123 ++++++++++++
 tb/tb_tt_um_rps_challenger.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared encodings for the RPS challenger: move codes, engine winner codes, FSM states.
// Also holds the LFSR seed, the fixed uio output-enable mask and a move sanitiser.
package rps_pkg;

  typedef enum logic [1:0] {
    MV_ROCK     = 2'b00,
    MV_PAPER    = 2'b01,
    MV_SCISSORS = 2'b10,
    MV_INVALID  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    WIN_TIE = 2'b00,
    WIN_P1  = 2'b01,
    WIN_P2  = 2'b10,
    WIN_BAD = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] UIO_OE    = 8'b0001_1111;

  // The engine has no meaning for code 11, so it is folded onto rock.
  function automatic logic [1:0] legal_move(input logic [1:0] m);
    return (m == MV_INVALID) ? MV_ROCK : m;
  endfunction

endpackage

// File: rtl/rps_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing a legal P2 move; one step per enabled cycle.
// No backpressure: free-running while ena is high, frozen otherwise.
module rps_lfsr
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] seed,
  output logic [1:0] move
);

  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= seed;
    end else if (ena) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign move = legal_move(lfsr[1:0]);

endmodule

// File: rtl/tt_um_rps_challenger.sv
// RPS engine initiator: on a go edge drives moves plus a 1-cycle start, samples the winner RESULT_DELAY+1 cycles later, keeps score.
// No backpressure: go edges outside IDLE are dropped; RPS_LFSR_EN selects an internal LFSR as the P2 move source.
module tt_um_rps_challenger
  import rps_pkg::*;
#(
  parameter int RESULT_DELAY = 2,
  parameter int WIN_TARGET   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] WIN_T    = 3'(WIN_TARGET);
  localparam logic [2:0] DLY_LAST = 3'(RESULT_DELAY - 1);

  state_t     state;
  logic [2:0] p1_wins, p2_wins;
  logic [2:0] p1_nxt, p2_nxt;
  logic [2:0] wait_cnt;
  logic [1:0] p1_mv, p2_mv, p2_src;
  logic       go_q, start, busy, match_over;

  wire go      = ui_in[2];
  wire clear   = ui_in[3];
  wire go_rise = go & ~go_q;
  wire [1:0] winner = uio_in[6:5];

`ifdef RPS_LFSR_EN
  rps_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .seed  (LFSR_SEED),
    .move  (p2_src)
  );
  logic unused;
  assign unused = &{1'b0, ui_in[7:4], uio_in[7], uio_in[4:0]};
`else
  assign p2_src = ui_in[6:5];
  logic unused;
  assign unused = &{1'b0, ui_in[7], ui_in[4], uio_in[7], uio_in[4:0]};
`endif

  // Saturate at the target so a stray result can never push a count past it.
  always_comb begin
    p1_nxt = p1_wins;
    p2_nxt = p2_wins;
    if (winner == WIN_P1 && p1_wins < WIN_T) p1_nxt = p1_wins + 3'd1;
    if (winner == WIN_P2 && p2_wins < WIN_T) p2_nxt = p2_wins + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      p1_wins    <= 3'd0;
      p2_wins    <= 3'd0;
      wait_cnt   <= 3'd0;
      p1_mv      <= 2'b00;
      p2_mv      <= 2'b00;
      go_q       <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      match_over <= 1'b0;
    end else if (ena) begin
      go_q <= go;
      if (clear) begin
        state      <= ST_IDLE;
        p1_wins    <= 3'd0;
        p2_wins    <= 3'd0;
        start      <= 1'b0;
        busy       <= 1'b0;
        match_over <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (go_rise) begin
              p1_mv <= ui_in[1:0];
              p2_mv <= p2_src;
              start <= 1'b1;
              busy  <= 1'b1;
              state <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            start    <= 1'b0;
            wait_cnt <= 3'd0;
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (wait_cnt == DLY_LAST) state <= ST_SAMPLE;
            else wait_cnt <= wait_cnt + 3'd1;
          end
          ST_SAMPLE: begin
            p1_wins <= p1_nxt;
            p2_wins <= p2_nxt;
            busy    <= 1'b0;
            if (p1_nxt == WIN_T || p2_nxt == WIN_T) begin
              match_over <= 1'b1;
              state      <= ST_DONE;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign uo_out  = {match_over, busy, p2_wins, p1_wins};
  assign uio_out = {3'b000, start, p2_mv, p1_mv};
  assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_tt_um_rps_challenger.sv
// Directed bench for tt_um_rps_challenger: acts as the RPS engine and checks start timing, scoring, match end, clear and reset.
// Under RPS_LFSR_EN it instead runs 50 rounds against a reference LFSR.
module tb_tt_um_rps_challenger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk = 0;
  int n_err = 0;

  tt_um_rps_challenger #(.RESULT_DELAY(2), .WIN_TARGET(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present moves, engine result and a go edge; returns just after the DRIVE edge.
  task automatic start_round(input logic [1:0] p1, input logic [1:0] p2, input logic [1:0] res);
    ui_in  = {1'b0, p2, 1'b0, 1'b0, 1'b1, p1};
    uio_in = {1'b0, res, 5'b0};
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !uo_out[6];
    end
    if (!done) chk("busy_timeout", {31'd0, uo_out[6]}, 32'd0);
  endtask

`ifdef RPS_LFSR_EN
  logic [7:0] ref_lfsr;
  always @(posedge clk) begin
    if (!rst_n) ref_lfsr <= 8'hA5;
    else if (ena) ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  end
`endif

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    cyc(2);
    chk("rst_uo_out", {24'd0, uo_out}, 32'h00);
    chk("rst_uio_out", {24'd0, uio_out}, 32'h00);
    chk("uio_oe", {24'd0, uio_oe}, 32'h1F);
    rst_n = 1'b1;
    cyc(1);

`ifdef RPS_LFSR_EN
    for (int r = 0; r < 50; r++) begin
      logic [1:0] exp_p2;
      exp_p2 = (ref_lfsr[1:0] == 2'b11) ? 2'b00 : ref_lfsr[1:0];
      start_round(2'b01, 2'b11, 2'b00);
      chk("lfsr_p2_legal", {31'd0, uio_out[3:2] == 2'b11}, 32'd0);
      chk("lfsr_p2_model", {30'd0, uio_out[3:2]}, {30'd0, exp_p2});
      ui_in = 8'h00;
      wait_idle();
    end
    chk("lfsr_no_score", {24'd0, uo_out}, 32'h00);
`else
    // P1 rock vs P2 scissors, engine says P1.
    start_round(2'b00, 2'b10, 2'b01);
    chk("r1_drive", {24'd0, uio_out}, 32'h18);
    chk("r1_busy", {31'd0, uo_out[6]}, 32'd1);
    ui_in[2] = 1'b0;
    cyc(1);
    chk("r1_start_drop", {24'd0, uio_out}, 32'h08);
    wait_idle();
    chk("r1_score", {24'd0, uo_out}, 32'h01);

    // Tie then invalid result: no score change.
    start_round(2'b01, 2'b01, 2'b00);
    ui_in[2] = 1'b0;
    wait_idle();
    chk("tie_score", {24'd0, uo_out}, 32'h01);
    start_round(2'b10, 2'b00, 2'b11);
    ui_in[2] = 1'b0;
    wait_idle();
    chk("bad_score", {24'd0, uo_out}, 32'h01);
    chk("bad_moves", {24'd0, uio_out}, 32'h02);

    // P2 win, with a second go edge during WAIT that must be dropped.
    start_round(2'b00, 2'b01, 2'b10);
    ui_in[2] = 1'b0;
    cyc(1);
    ui_in[2] = 1'b1;
    cyc(1);
    ui_in[2] = 1'b0;
    wait_idle();
    chk("p2_score", {24'd0, uo_out}, 32'h09);
    cyc(3);
    chk("no_queued_go", {24'd0, uio_out}, 32'h04);
    chk("no_queued_busy", {31'd0, uo_out[6]}, 32'd0);

    // Two more P1 wins end the match at 3.
    for (int r = 0; r < 2; r++) begin
      start_round(2'b01, 2'b00, 2'b01);
      ui_in[2] = 1'b0;
      wait_idle();
    end
    chk("match_over", {24'd0, uo_out}, 32'h8B);

    // go in DONE is ignored.
    start_round(2'b00, 2'b00, 2'b01);
    chk("done_no_start", {31'd0, uio_out[4]}, 32'd0);
    ui_in[2] = 1'b0;
    cyc(4);
    chk("done_hold", {24'd0, uo_out}, 32'h8B);

    // go and clear together in DONE: clear wins, no start.
    ui_in = 8'h0C;
    cyc(1);
    chk("clr_uo_out", {24'd0, uo_out}, 32'h00);
    chk("clr_no_start", {31'd0, uio_out[4]}, 32'd0);
    ui_in = 8'h04;
    cyc(1);
    chk("clr_go_consumed", {31'd0, uio_out[4]}, 32'd0);
    chk("clr_idle", {24'd0, uo_out}, 32'h00);
    ui_in = 8'h00;
    cyc(1);

    // go edge arriving while ena is low is seen once ena returns.
    ena    = 1'b0;
    ui_in  = 8'h45;
    uio_in = 8'h20;
    cyc(3);
    chk("ena_hold_start", {31'd0, uio_out[4]}, 32'd0);
    chk("ena_hold_uo", {24'd0, uo_out}, 32'h00);
    ena = 1'b1;
    cyc(1);
    chk("ena_resume", {24'd0, uio_out}, 32'h19);
    ui_in[2] = 1'b0;
    wait_idle();
    chk("ena_score", {24'd0, uo_out}, 32'h01);

    // Reset during DRIVE drops start next cycle.
    start_round(2'b01, 2'b01, 2'b01);
    ui_in[2] = 1'b0;
    rst_n = 1'b0;
    cyc(1);
    chk("rst_drive_start", {31'd0, uio_out[4]}, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Reset during WAIT: outputs clear and the pending result is never scored.
    start_round(2'b10, 2'b01, 2'b01);
    ui_in[2] = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    chk("rst_wait_uio", {24'd0, uio_out}, 32'h00);
    chk("rst_wait_uo", {24'd0, uo_out}, 32'h00);
    rst_n = 1'b1;
    cyc(8);
    chk("rst_wait_noscore", {24'd0, uo_out}, 32'h00);
    chk("rst_wait_nostart", {24'd0, uio_out}, 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
